// File: rtl/snake_input_pkg.sv
// Shared constants for the push-button front end of the snake game.
// Holds the button index map, the default timing derived from the
// 25.175 MHz VGA pixel clock, the phase/pause state type and a helper
// for sizing counters.
package snake_input_pkg;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;
  localparam int unsigned NUM_BUTTONS = 5;

  localparam int unsigned PIXEL_CLK_HZ = 25_175_000;
  // 10 ms of stable input before a change is accepted
  localparam int unsigned DEBOUNCE_CYCLES_DEF = PIXEL_CLK_HZ / 100;
  // roughly a quarter second per phase half-period
  localparam int unsigned PHASE_PERIOD_DEF = 6_293_504;

  typedef enum logic {
    PH_RUN    = 1'b0,
    PH_PAUSED = 1'b1
  } phase_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_input_conditioner_if.sv
// Button bundle between the board pins / game core and the conditioner.
//   i_btn         raw asynchronous button levels, 1 = pressed
//   o_btn_level   debounced levels
//   o_btn_press   1-cycle pulse on debounced rise
//   o_btn_release 1-cycle pulse on debounced fall
//   o_phase       game phase, toggles every phase period unless paused
//   o_tick        1-cycle pulse when o_phase toggles
//   o_pause       pause state, toggled by center presses
// master: the side that drives the buttons and consumes the outputs.
// slave:  the conditioner itself.
interface button_input_conditioner_if #(
  parameter int unsigned N_BTN = snake_input_pkg::NUM_BUTTONS
);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_btn_level;
  logic [N_BTN-1:0] o_btn_press;
  logic [N_BTN-1:0] o_btn_release;
  logic             o_phase;
  logic             o_tick;
  logic             o_pause;

  modport master (
    output i_btn,
    input  o_btn_level, o_btn_press, o_btn_release, o_phase, o_tick, o_pause
  );

  modport slave (
    input  i_btn,
    output o_btn_level, o_btn_press, o_btn_release, o_phase, o_tick, o_pause
  );
endinterface

// File: rtl/button_debounce_bit.sv
// Single-button conditioner: synchroniser chain, debounce counter,
// accepted (stable) level and registered press/release pulses.
//   clk       pixel clock
//   rst       synchronous reset, active-high
//   i_raw     raw asynchronous button level
//   o_level   debounced level
//   o_press   high for the first cycle o_level shows 1
//   o_release high for the first cycle o_level shows 0
module button_debounce_bit
  import snake_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_press;
  logic                   r_release;
  logic                   w_synced;
  logic                   w_accept;

  assign w_synced = r_sync[SYNC_STAGES-1];
  // The counter only advances while synced differs from stable, so reaching
  // CNT_MAX means DEBOUNCE_CYCLES consecutive differing samples.
  assign w_accept = (w_synced != r_stable) && (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_stable  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // Pulses are registered alongside r_stable so they line up with the
      // first cycle of the new level.
      r_press   <= w_accept &  w_synced;
      r_release <= w_accept & ~w_synced;
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= w_synced;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_input_conditioner.sv
// Front end between the board push-buttons and the snake game core.
// Debounces all buttons, produces press/release pulses, and generates the
// game phase/tick with a pause toggled by the center button.
//   clk  VGA pixel clock (only clock)
//   rst  synchronous reset, active-high
//   bus  button bundle (slave side): i_btn in; o_btn_level, o_btn_press,
//        o_btn_release, o_phase, o_tick, o_pause out
//
// Pause state machine:
//   state     | meaning
//   PH_RUN    | phase toggles and tick fires on every counter wrap
//   PH_PAUSED | counter keeps running, wraps produce no toggle or tick
module button_input_conditioner
  import snake_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PHASE_PERIOD    = PHASE_PERIOD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  button_input_conditioner_if.slave     bus
);

  localparam int unsigned PH_W = cnt_width(PHASE_PERIOD);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(PHASE_PERIOD - 1);

  logic [NUM_BUTTONS-1:0] w_level;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_release;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (bus.i_btn[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  phase_state_e     r_state;
  phase_state_e     w_state_nxt;
  logic [PH_W-1:0]  r_ph_cnt;
  logic             r_phase;
  logic             r_tick;
  logic             w_wrap;
  logic             w_toggle;

  assign w_wrap = (r_ph_cnt == PH_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_toggle    = 1'b0;
    case (r_state)
      PH_RUN: begin
        w_toggle = w_wrap;
        if (w_press[BTN_CENTER]) w_state_nxt = PH_PAUSED;
      end
      PH_PAUSED: begin
        if (w_press[BTN_CENTER]) w_state_nxt = PH_RUN;
      end
      default: w_state_nxt = PH_RUN;
    endcase
  end

  // The wrap decision uses the pre-edge pause state; a center press on the
  // same edge only affects the following wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PH_RUN;
      r_ph_cnt <= '0;
      r_phase  <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ph_cnt <= w_wrap ? '0 : r_ph_cnt + 1'b1;
      r_tick   <= w_toggle;
      if (w_toggle) r_phase <= ~r_phase;
    end
  end

  assign bus.o_btn_level   = w_level;
  assign bus.o_btn_press   = w_press;
  assign bus.o_btn_release = w_release;
  assign bus.o_phase       = r_phase;
  assign bus.o_tick        = r_tick;
  assign bus.o_pause       = (r_state == PH_PAUSED);

endmodule

// File: tb/tb_button_input_conditioner.sv
module tb_button_input_conditioner;
  import snake_input_pkg::*;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int PP = 8;
  localparam int NB = NUM_BUTTONS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_input_conditioner_if #(.N_BTN(NB)) bus ();

  button_input_conditioner #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .PHASE_PERIOD    (PP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: raw input delayed through SS samples; a level changes
  // once the last DB synced samples all disagree with it.
  logic [NB-1:0] m_raw;
  logic [NB-1:0] m_pipe [SS];
  logic [DB-1:0] m_hist [NB];
  logic [NB-1:0] m_level, m_press, m_rel;
  logic          m_phase, m_tick, m_pause;
  int            m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_pipe[s] = '0;
    for (int b = 0; b < NB; b++) m_hist[b] = '0;
    m_level = '0; m_press = '0; m_rel = '0;
    m_phase = 1'b0; m_tick = 1'b0; m_pause = 1'b0;
    m_cyc = 0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] synced_prev;
    if (rst) begin
      model_reset();
      return;
    end
    synced_prev = m_pipe[SS-1];
    m_cyc++;
    m_tick = ((m_cyc % PP) == 0) && !m_pause;
    if (m_tick) m_phase = !m_phase;
    if (m_press[BTN_CENTER]) m_pause = !m_pause;
    m_press = '0;
    m_rel   = '0;
    for (int b = 0; b < NB; b++) begin
      m_hist[b] = {m_hist[b][DB-2:0], synced_prev[b]};
      if (m_hist[b] == {DB{!m_level[b]}}) begin
        m_level[b] = !m_level[b];
        if (m_level[b]) m_press[b] = 1'b1;
        else            m_rel[b]   = 1'b1;
      end
    end
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = m_raw;
  endtask

  task automatic check_all();
    chk("level",   32'(bus.o_btn_level),   32'(m_level));
    chk("press",   32'(bus.o_btn_press),   32'(m_press));
    chk("release", 32'(bus.o_btn_release), 32'(m_rel));
    chk("phase",   32'(bus.o_phase),       32'(m_phase));
    chk("tick",    32'(bus.o_tick),        32'(m_tick));
    chk("pause",   32'(bus.o_pause),       32'(m_pause));
  endtask

  // Drive raw buttons, take one edge, sample 1 time unit later.
  task automatic step(input logic [NB-1:0] btn);
    bus.i_btn = btn;
    m_raw     = btn;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_level"}, 32'(bus.o_btn_level), 32'h0);
    chk({tag, "_press"}, 32'(bus.o_btn_press), 32'h0);
    chk({tag, "_rel"},   32'(bus.o_btn_release), 32'h0);
    chk({tag, "_phase"}, 32'(bus.o_phase), 32'h0);
    chk({tag, "_tick"},  32'(bus.o_tick), 32'h0);
    chk({tag, "_pause"}, 32'(bus.o_pause), 32'h0);
  endtask

  task automatic do_reset(input logic [NB-1:0] btn);
    rst = 1'b1;
    step(btn);
    step(btn);
    check_all_zero("rst");
    rst = 1'b0;
  endtask

  initial begin
    int presses;
    int hold [NB];
    logic [NB-1:0] rnd;

    rst       = 1'b1;
    bus.i_btn = '0;
    m_raw     = '0;
    model_reset();

    // Clean press on bit 0, plus phase timing from reset.
    do_reset('0);
    for (int k = 1; k <= 24; k++) begin
      step(5'b00001);
      if (k == 5) chk("t1_level_early", 32'(bus.o_btn_level), 32'h0);
      if (k == 6) begin
        chk("t1_level", 32'(bus.o_btn_level), 32'h01);
        chk("t1_press", 32'(bus.o_btn_press), 32'h01);
      end
      if (k == 7) chk("t1_press_gone", 32'(bus.o_btn_press), 32'h0);
      if (k == 7)  chk("t4_tick_7",  32'(bus.o_tick), 32'h0);
      if (k == 8)  chk("t4_phase_8", 32'({bus.o_phase, bus.o_tick}), 32'h3);
      if (k == 16) chk("t4_phase_16", 32'({bus.o_phase, bus.o_tick}), 32'h1);
      if (k == 24) chk("t4_phase_24", 32'({bus.o_phase, bus.o_tick}), 32'h3);
    end

    // Bounce on bit 2, then release.
    do_reset('0);
    presses = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k <= 3)       step(5'b00100);
      else if (k == 4)  step(5'b00000);
      else if (k <= 20) step(5'b00100);
      else              step(5'b00000);
      if (bus.o_btn_press[2]) presses++;
      if (k == 9)  chk("t2_no_press_9", 32'(bus.o_btn_press), 32'h0);
      if (k == 10) chk("t2_press_10", 32'(bus.o_btn_press), 32'h04);
      if (k == 25) chk("t3_level_25", 32'(bus.o_btn_level), 32'h04);
      if (k == 26) chk("t3_release_26", 32'({bus.o_btn_release, bus.o_btn_level}), 32'h080);
    end
    chk("t2_press_count", 32'(presses), 32'd1);

    // Pause with center, then resume.
    do_reset('0);
    for (int k = 1; k <= 40; k++) begin
      if ((k <= 10) || (k >= 21 && k <= 30)) step(5'b10000);
      else                                   step(5'b00000);
      if (k == 6)  chk("t5_pause_6", 32'(bus.o_pause), 32'h0);
      if (k == 7)  chk("t5_pause_7", 32'(bus.o_pause), 32'h1);
      if (k == 8)  chk("t5_frozen_8",  32'({bus.o_phase, bus.o_tick}), 32'h0);
      if (k == 16) chk("t5_frozen_16", 32'({bus.o_phase, bus.o_tick}), 32'h0);
      if (k == 24) chk("t5_frozen_24", 32'({bus.o_phase, bus.o_tick}), 32'h0);
      if (k == 27) chk("t5_resume_27", 32'(bus.o_pause), 32'h0);
      if (k == 32) chk("t5_toggle_32", 32'({bus.o_phase, bus.o_tick}), 32'h3);
    end

    // Randomised hold lengths on every button, including short glitches.
    do_reset('0);
    for (int b = 0; b < NB; b++) hold[b] = 0;
    rnd = '0;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NB; b++) begin
        if (hold[b] == 0) begin
          rnd[b]  = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 8));
        end
        hold[b]--;
      end
      step(rnd);
    end

    // Reset in the middle of a debounce with bit 1 held.
    do_reset('0);
    for (int k = 1; k <= 4; k++) step(5'b00010);
    do_reset(5'b00010);
    for (int k = 1; k <= 8; k++) begin
      step(5'b00010);
      if (k == 5) chk("t6_level_5", 32'(bus.o_btn_level), 32'h0);
      if (k == 6) chk("t6_press_6", 32'(bus.o_btn_press), 32'h02);
      if (k == 7) chk("t6_phase_7", 32'({bus.o_phase, bus.o_tick}), 32'h0);
      if (k == 8) chk("t6_phase_8", 32'({bus.o_phase, bus.o_tick}), 32'h3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
